// File: rtl/bram_stream_reader.sv
// bram_stream_reader: drains a dual-port RAM byte ring onto a valid/ready stream through a 3-entry skid buffer.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   avail,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [ADDR_WIDTH:0]   issue_ptr_q, issue_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];
  logic [1:0]            cnt_q, cnt_d, cnt_pop;
  logic                  issue, push, pop;
  assign avail     = wr_ptr - issue_ptr_q;
  assign ram_addr  = issue_ptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = buf_q[0];
  // Head stays in place when the last byte pops, so out_data holds its value while idle.
  always_comb begin
    pop         = out_valid & out_ready & ~flush;
    push        = inflight_q & ~flush;
    issue       = enable & ~flush & (avail != '0) & (({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'd3);
    cnt_pop     = cnt_q - {1'b0, pop};
    buf_d       = buf_q;
    if (pop) begin
      buf_d[0] = cnt_q > 2'd1 ? buf_q[1] : buf_q[0];
      buf_d[1] = buf_q[2];
    end
    if (push)
      for (int i = 0; i < 3; i++)
        if (cnt_pop == i[1:0]) buf_d[i] = ram_data;
    cnt_d       = flush ? 2'd0 : cnt_pop + {1'b0, push};
    inflight_d  = issue;
    issue_ptr_d = flush ? wr_ptr : issue_ptr_q + {{ADDR_WIDTH{1'b0}}, issue};
    rd_ptr_d    = flush ? wr_ptr : rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_ptr_q <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      cnt_q       <= 2'd0;
      buf_q       <= '{default: '0};
    end else begin
      issue_ptr_q <= issue_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed tests plus a ring-buffer reference that checks every emitted byte and pointer.
module tb_bram_stream_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic [11:0] wr_ptr = '0;
  logic [11:0] rd_ptr, avail;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  mem [2048];
  logic [11:0] m_rd = '0;
  logic [11:0] occ;
  logic        chk_en = 1'b0;
  int          n_vec = 0, n_err = 0, pops = 0, p0 = 0;

  bram_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr), .avail(avail), .ram_addr(ram_addr), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_data <= mem[ram_addr];
  assign occ = wr_ptr - avail - rd_ptr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the stream must be exactly the ring contents starting at the consumed pointer.
  always @(negedge clk) if (chk_en) begin
    chk("rd_ptr_track", 32'(rd_ptr), 32'(m_rd));
    chk("occupancy_le3", 32'(occ <= 12'd3), 32'd1);
    if (!reset_n) m_rd <= '0;
    else if (flush) m_rd <= wr_ptr;
    else if (out_valid && out_ready) begin
      chk("stream_byte", 32'(out_data), 32'(mem[m_rd[10:0]]));
      m_rd <= m_rd + 12'd1;
      pops <= pops + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    step(); step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_avail", 32'(avail), 32'd0);
    // basic: five bytes, first valid in the cycle after w+2
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) mem[i] = 8'h10 + 8'(i);
    wr_ptr = 12'd5;
    @(negedge clk); chk("basic_lat_w", 32'(out_valid), 32'd0);
    @(negedge clk); chk("basic_lat_w1", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data", 32'(out_data), 32'h10 + 32'(i));
    end
    @(negedge clk);
    chk("basic_drained", 32'(out_valid), 32'd0);
    chk("basic_rd_ptr", 32'(rd_ptr), 32'd5);
    chk("basic_avail", 32'(avail), 32'd0);
    chk("basic_hold", 32'(out_data), 32'h14);
    // backpressure: 100 bytes, stalled consumer
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 100; i++) mem[5 + i] = 8'(i * 7 + 3);
    wr_ptr = 12'd105;
    p0 = pops;
    repeat (10) step();
    chk("bp_ram_addr", 32'(ram_addr), 32'd8);
    chk("bp_avail", 32'(avail), 32'd97);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'd3);
    for (int i = 0; i < 3000 && rd_ptr != 12'd105; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    chk("bp_rd_ptr", 32'(rd_ptr), 32'd105);
    chk("bp_pop_count", 32'(pops - p0), 32'd100);
    // wrap: pointers preset via flush
    wr_ptr = 12'h7FE;
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem[2046] = 8'hA0; mem[2047] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
    wr_ptr = 12'h802;
    @(negedge clk); chk("wrap_addr0", 32'(ram_addr), 32'd2046);
    @(negedge clk); chk("wrap_addr1", 32'(ram_addr), 32'd2047);
    @(negedge clk); chk("wrap_addr2", 32'(ram_addr), 32'd0);
    chk("wrap_d0", 32'(out_data), 32'hA0);
    @(negedge clk); chk("wrap_addr3", 32'(ram_addr), 32'd1);
    chk("wrap_d1", 32'(out_data), 32'hA1);
    @(negedge clk); chk("wrap_d2", 32'(out_data), 32'hA2);
    @(negedge clk); chk("wrap_d3", 32'(out_data), 32'hA3);
    chk("wrap_v3", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("wrap_rd_ptr", 32'(rd_ptr), 32'h802);
    chk("wrap_drained", 32'(out_valid), 32'd0);
    // flush mid-stream with one buffered byte and one read in flight
    step();
    wr_ptr = 12'd0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) mem[i] = 8'hB0 + 8'(i);
    wr_ptr = 12'd20;
    for (int i = 0; i < 100 && rd_ptr != 12'd5; i++) step();
    chk("fl_reach5", 32'(rd_ptr), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_rd_ptr", 32'(rd_ptr), 32'd20);
    chk("fl_avail", 32'(avail), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fl_no_stale", 32'(out_valid), 32'd0);
    end
    // reset mid-stream
    step();
    for (int i = 0; i < 40; i++) mem[20 + i] = 8'hD0 + 8'(i);
    wr_ptr = 12'd60;
    for (int i = 0; i < 100 && rd_ptr != 12'd25; i++) step();
    chk("rs_reach25", 32'(rd_ptr), 32'd25);
    reset_n = 1'b0;
    wr_ptr = 12'd0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_data", 32'(out_data), 32'd0);
    chk("rs_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rs_avail", 32'(avail), 32'd0);
    chk("rs_ram_addr", 32'(ram_addr), 32'd0);
    // enable=0 after the buffer fills: only buffered bytes drain
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
    wr_ptr = 12'd8;
    repeat (6) step();
    enable = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    repeat (10) step();
    chk("en_pops", 32'(pops - p0), 32'd3);
    chk("en_avail", 32'(avail), 32'd5);
    chk("en_stalled", 32'(out_valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 100 && rd_ptr != 12'd8; i++) step();
    chk("en_rd_ptr", 32'(rd_ptr), 32'd8);
    chk("en_avail_end", 32'(avail), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
